// File: rtl/regwb_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// FSM state encoding and the grant selector type.
package regwb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AREG_DEF = 5;

    // 3-bit encodings for the occupancy/age FSM.
    localparam logic [2:0] ST_EMPTY        = 3'd0;
    localparam logic [2:0] ST_ALU_ONLY     = 3'd1;
    localparam logic [2:0] ST_MEM_ONLY     = 3'd2;
    localparam logic [2:0] ST_BOTH_ALU_OLD = 3'd3;
    localparam logic [2:0] ST_BOTH_MEM_OLD = 3'd4;

    typedef enum logic [2:0] {
        EMPTY        = ST_EMPTY,
        ALU_ONLY     = ST_ALU_ONLY,
        MEM_ONLY     = ST_MEM_ONLY,
        BOTH_ALU_OLD = ST_BOTH_ALU_OLD,
        BOTH_MEM_OLD = ST_BOTH_MEM_OLD
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

endpackage

// File: rtl/regwb_slot.sv
// One-entry writeback holding buffer (valid, rd, data). A load on the same
// edge as a free refills the slot; otherwise free empties it.
module regwb_slot
    import regwb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AREG = AREG_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            free,
    input  logic [AREG-1:0] load_rd,
    input  logic [XLEN-1:0] load_data,
    output logic            valid,
    output logic [AREG-1:0] rd,
    output logic [XLEN-1:0] data
);

    // Slot register: load has priority over free so a granted slot can refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            // NOTE: the payload is reset too, not just valid, so the muxed
            // rf_rd/rf_wdata path never carries X out of reset.
            rd    <= '0;
            data  <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            valid <= 1'b1;
            rd    <= load_rd;
            data  <= load_data;
        end else if (free) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and the
// load unit, retiring writes oldest-first. Outputs are registered.
// Optional feature: define REGWB_CONFLICT_CNT_EN to add conflict_cnt, a
// saturating count of cycles in which both holding slots are occupied.
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AREG = AREG_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AREG-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AREG-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            rf_we,
    output logic [AREG-1:0] rf_rd,
    output logic [XLEN-1:0] rf_wdata
`ifdef REGWB_CONFLICT_CNT_EN
    ,
    output logic [31:0]     conflict_cnt
`endif
);

    state_t          state;
    state_t          state_next;
    grant_t          grant;

    logic            alu_q_valid;
    logic [AREG-1:0] alu_q_rd;
    logic [XLEN-1:0] alu_q_data;
    logic            mem_q_valid;
    logic [AREG-1:0] mem_q_rd;
    logic [XLEN-1:0] mem_q_data;

    logic            grant_alu;
    logic            grant_mem;
    logic            alu_load;
    logic            mem_load;
    logic            alu_keep;
    logic            mem_keep;
    logic            alu_occ_next;
    logic            mem_occ_next;

    assign grant_alu = (grant == GNT_ALU);
    assign grant_mem = (grant == GNT_MEM);

    // A slot is free to accept when empty or when it drains this cycle.
    assign alu_ready = rst_n & (~alu_q_valid | grant_alu);
    assign mem_ready = rst_n & (~mem_q_valid | grant_mem);

    // Writes to x0 complete the handshake but never enter a slot.
    assign alu_load  = alu_valid & alu_ready & (alu_rd != '0);
    assign mem_load  = mem_valid & mem_ready & (mem_rd != '0);

    assign alu_keep     = alu_q_valid & ~grant_alu;
    assign mem_keep     = mem_q_valid & ~grant_mem;
    assign alu_occ_next = alu_keep | alu_load;
    assign mem_occ_next = mem_keep | mem_load;

    regwb_slot #(.XLEN(XLEN), .AREG(AREG)) u_alu_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (alu_load),
        .free      (grant_alu),
        .load_rd   (alu_rd),
        .load_data (alu_data),
        .valid     (alu_q_valid),
        .rd        (alu_q_rd),
        .data      (alu_q_data)
    );

    regwb_slot #(.XLEN(XLEN), .AREG(AREG)) u_mem_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mem_load),
        .free      (grant_mem),
        .load_rd   (mem_rd),
        .load_data (mem_data),
        .valid     (mem_q_valid),
        .rd        (mem_q_rd),
        .data      (mem_q_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Grant the older occupant; track occupancy and relative age for next cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        grant      = GNT_NONE;
        state_next = EMPTY;

        case (state)
            ALU_ONLY:     grant = GNT_ALU;
            MEM_ONLY:     grant = GNT_MEM;
            BOTH_ALU_OLD: grant = GNT_ALU;
            BOTH_MEM_OLD: grant = GNT_MEM;
            default:      grant = GNT_NONE;
        endcase

        // A surviving entry is always older than a fresh one; two fresh
        // entries on the same edge rank MEM as older (deeper stage).
        if (alu_occ_next && mem_occ_next) begin
            if (alu_keep) begin
                state_next = BOTH_ALU_OLD;
            end else begin
                state_next = BOTH_MEM_OLD;
            end
        end else if (alu_occ_next) begin
            state_next = ALU_ONLY;
        end else if (mem_occ_next) begin
            state_next = MEM_ONLY;
        end else begin
            state_next = EMPTY;
        end
    end

    // Registered register-file write port; index/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_alu | grant_mem;
            if (grant_mem) begin
                rf_rd    <= mem_q_rd;
                rf_wdata <= mem_q_data;
            end else if (grant_alu) begin
                rf_rd    <= alu_q_rd;
                rf_wdata <= alu_q_data;
            end
        end
    end

`ifdef REGWB_CONFLICT_CNT_EN
    // Saturating count of cycles spent with both slots occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (((state == BOTH_ALU_OLD) || (state == BOTH_MEM_OLD)) &&
                     (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: accepted writes are queued in
// acceptance order (same-edge pair: MEM first) and popped when rf_we fires.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
`ifdef REGWB_CONFLICT_CNT_EN
    logic [31:0] conflict_cnt;
`endif

    int          tests  = 0;
    int          failed = 0;
    wr_t         sb[$];
    int          occ        = 0;
    int          conf_model = 0;
    logic        alu_acc;
    logic        mem_acc;
    logic [31:0] obs_rf [32];

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata)
`ifdef REGWB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: compare what the last posedge produced.
    task automatic monitor();
        wr_t e;
        check("rf_we", {63'd0, rf_we}, {63'd0, (occ > 0)});
        if (rf_we && sb.size() > 0) begin
            e = sb.pop_front();
            check("rf_rd", {59'd0, rf_rd}, {59'd0, e.rd});
            check("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.data});
            obs_rf[rf_rd] = rf_wdata;
        end
        if (occ == 2) conf_model++;
        occ = sb.size();
    endtask

    // Drive one cycle of stimulus from a negedge, record accepted writes,
    // then advance to the next negedge and check the outputs.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
        wr_t e;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        #1;
        mem_acc = mv & mem_ready;
        alu_acc = av & alu_ready;
        if (mem_acc && mr != 5'd0) begin e.rd = mr; e.data = md; sb.push_back(e); end
        if (alu_acc && ar != 5'd0) begin e.rd = ar; e.data = ad; sb.push_back(e); end
        @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        monitor();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_reset_state();
        check("rst_rf_we", {63'd0, rf_we}, 64'd0);
        check("rst_rf_rd", {59'd0, rf_rd}, 64'd0);
        check("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
`ifdef REGWB_CONFLICT_CNT_EN
        check("rst_conflict_cnt", {32'd0, conflict_cnt}, 64'd0);
`endif
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst_alu", {63'd0, alu_ready}, 64'd1);
        check("ready_after_rst_mem", {63'd0, mem_ready}, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [4:0]  r;
        logic [31:0] d;
        logic [4:0]  r2;
        logic [31:0] d2;

        for (int i = 0; i < 32; i++) obs_rf[i] = 32'd0;
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        #1;
        check_reset_state();
        release_reset();

        // Single ALU write: one idle-visible cycle, then exactly one write.
        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        check("t2_alu_acc", {63'd0, alu_acc}, 64'd1);
        idle(3);

        // Same rd, same edge: MEM retires first, ALU value is final.
        step(1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd3, 32'hBBBB_0002);
        check("t3_mem_ready_both", {63'd0, mem_ready}, 64'd1);
        check("t3_alu_ready_both", {63'd0, alu_ready}, 64'd0);
        idle(3);
        check("t3_x3_final", {32'd0, obs_rf[3]}, {32'd0, 32'hAAAA_0001});

        // MEM then ALU to the same rd on consecutive edges.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hC0C0_0007);
        check("t4_alu_ready", {63'd0, alu_ready}, 64'd1);
        check("t4_mem_ready", {63'd0, mem_ready}, 64'd1);
        step(1'b1, 5'd7, 32'hD0D0_0007, 1'b0, 5'd0, 32'd0);
        idle(3);
        check("t4_x7_final", {32'd0, obs_rf[7]}, {32'd0, 32'hD0D0_0007});

        // x0 writes: handshake completes, nothing retires.
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        check("t6_alu_x0_acc", {63'd0, alu_acc}, 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check("t6_mem_x0_acc", {63'd0, mem_acc}, 64'd1);
        idle(3);

        // Both sources streaming: one write per cycle, order preserved.
        for (int i = 0; i < 20; i++) begin
            r  = 5'($urandom_range(4, 1));
            d  = $urandom;
            r2 = 5'($urandom_range(4, 1));
            d2 = $urandom;
            step(1'b1, r, d, 1'b1, r2, d2);
        end
        idle(4);
        check("t5_drained", 64'(sb.size()), 64'd0);
`ifdef REGWB_CONFLICT_CNT_EN
        check("t5_conflict_cnt", {32'd0, conflict_cnt}, 64'(conf_model));
`endif

        // Reset mid-stream drops pending writes and clears outputs at once.
        step(1'b1, 5'd9, 32'h9999_0009, 1'b1, 5'd10, 32'hAAAA_000A);
        step(1'b1, 5'd11, 32'hBBBB_000B, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        sb.delete();
        occ = 0;
        conf_model = 0;
        release_reset();
        idle(2);
        step(1'b1, 5'd12, 32'h5A5A_A5A5, 1'b0, 5'd0, 32'd0);
        idle(2);
        check("post_rst_x12", {32'd0, obs_rf[12]}, {32'd0, 32'h5A5A_A5A5});
        check("post_rst_drained", 64'(sb.size()), 64'd0);
`ifdef REGWB_CONFLICT_CNT_EN
        check("post_rst_conflict_cnt", {32'd0, conflict_cnt}, 64'(conf_model));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
